// File: rtl/serdes_tx.sv
// Serializing transmitter: frames 8-bit words behind a sync word and emits an NRZ
// stream at BIT_DIV clocks per bit; a toggling idle pattern keeps the far-end CDR locked.
module serdes_tx #(
    parameter int          BIT_DIV   = 4,
    parameter logic [7:0]  SYNC_WORD = 8'hD5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       frame_active,
    output logic       word_done
);
    localparam int             TW     = $clog2(BIT_DIV);
    localparam logic [TW-1:0]  T_LAST = TW'(BIT_DIV - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

    state_t        state;
    logic [TW-1:0] bit_tmr;
    logic [3:0]    frame_cnt;
    logic [7:0]    hold_data;
    logic          hold_full;
    logic [7:0]    shifter;
    logic          parity;
    logic          boundary;
    logic [2:0]    sync_idx;

    assign boundary = (bit_tmr == T_LAST);
    assign sync_idx = frame_cnt[2:0] + 3'd1;
    assign tx_ready = !hold_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            bit_tmr      <= '0;
            frame_cnt    <= '0;
            hold_data    <= '0;
            hold_full    <= 1'b0;
            shifter      <= '0;
            parity       <= 1'b0;
            serial_out   <= 1'b0;
            frame_active <= 1'b0;
            word_done    <= 1'b0;
        end else begin
            word_done <= 1'b0;
            bit_tmr   <= boundary ? '0 : bit_tmr + TW'(1);

            // Accept only when empty; the load below only fires when full, so they never collide.
            if (tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end

            if (boundary) begin
                case (state)
                    IDLE: begin
                        if (hold_full) begin
                            state        <= SYNC;
                            frame_cnt    <= '0;
                            frame_active <= 1'b1;
                            serial_out   <= SYNC_WORD[0];
                        end else begin
                            serial_out <= ~serial_out;
                        end
                    end
                    SYNC: begin
                        if (frame_cnt == 4'd7) begin
                            state      <= DATA;
                            frame_cnt  <= '0;
                            shifter    <= hold_data;
                            parity     <= ^hold_data;
                            hold_full  <= 1'b0;
                            serial_out <= 1'b1;
                        end else begin
                            frame_cnt  <= frame_cnt + 4'd1;
                            serial_out <= SYNC_WORD[sync_idx];
                        end
                    end
                    DATA: begin
                        // frame_cnt is the bit currently on the wire: 0 start, 1..8 data, 9 parity
                        if (frame_cnt == 4'd9) begin
                            word_done <= 1'b1;
                            frame_cnt <= '0;
                            if (hold_full) begin
                                shifter    <= hold_data;
                                parity     <= ^hold_data;
                                hold_full  <= 1'b0;
                                serial_out <= 1'b1;
                            end else begin
                                state        <= IDLE;
                                frame_active <= 1'b0;
                                serial_out   <= ~parity;
                            end
                        end else if (frame_cnt == 4'd8) begin
                            serial_out <= parity;
                            frame_cnt  <= frame_cnt + 4'd1;
                        end else begin
                            serial_out <= shifter[0];
                            shifter    <= {1'b0, shifter[7:1]};
                            frame_cnt  <= frame_cnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serdes_tx.sv
// Directed bench for serdes_tx: BIT_DIV=4 and BIT_DIV=2 instances share inputs,
// bit periods are walked cycle by cycle against hand-computed streams.
module tb_serdes_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       so4, rdy4, fa4, wd4;
    logic       so2, rdy2, fa2, wd2;
    logic       so, rdy, fa, wd;
    logic       sel;
    logic       inc_en;
    logic       rdy_lo_chk;
    logic       exp_idle;
    int         bd;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         wd_q[$];
    logic [7:0] sync_w = 8'hD5;

    serdes_tx #(.BIT_DIV(4), .SYNC_WORD(8'hD5)) u4 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy4),
        .serial_out(so4), .frame_active(fa4), .word_done(wd4));

    serdes_tx #(.BIT_DIV(2), .SYNC_WORD(8'hD5)) u2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy2),
        .serial_out(so2), .frame_active(fa2), .word_done(wd2));

    always #5 clk = ~clk;

    always_comb begin
        so  = sel ? so2  : so4;
        rdy = sel ? rdy2 : rdy4;
        fa  = sel ? fa2  : fa4;
        wd  = sel ? wd2  : wd4;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (wd) wd_q.push_back(cyc);
    always @(negedge clk) if (inc_en) tx_data <= tx_data + 8'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a boundary; leaves just after the next one.
    task automatic chk_bit(input string tag, input logic e_so, input logic e_fa, input logic e_wd);
        chk({tag, "_so"}, so, e_so);
        chk({tag, "_fa"}, fa, e_fa);
        chk({tag, "_wd"}, wd, e_wd);
        for (int i = 1; i < bd; i++) begin
            step();
            chk({tag, "_so_hold"}, so, e_so);
            chk({tag, "_wd_hold"}, wd, 1'b0);
            if (rdy_lo_chk) chk({tag, "_rdy_lo"}, rdy, 1'b0);
        end
        step();
    endtask

    task automatic release_align();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i < bd; i++) begin
            step();
            chk("first_bd_so", so, 1'b0);
        end
        step();
        exp_idle = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) begin
            chk_bit("idle", exp_idle, 1'b0, 1'b0);
            exp_idle = ~exp_idle;
        end
    endtask

    task automatic idle_send(input logic [7:0] d);
        chk("send_rdy", rdy, 1'b1);
        chk("send_idle_so", so, exp_idle);
        tx_valid = 1'b1;
        tx_data  = d;
        step();
        tx_valid = 1'b0;
        chk("rdy_fall", rdy, 1'b0);
        for (int i = 1; i < bd; i++) step();
    endtask

    task automatic sync_bits();
        for (int i = 0; i < 8; i++) chk_bit("sync", sync_w[i], 1'b1, 1'b0);
    endtask

    task automatic data_frame(input logic [7:0] d, input logic p, input logic wd0,
                              input logic nv, input logic [7:0] nd);
        if (nv) begin
            tx_valid = 1'b1;
            tx_data  = nd;
        end
        chk_bit("start", 1'b1, 1'b1, wd0);
        if (nv) begin
            tx_valid = 1'b0;
            chk("rdy_pending", rdy, 1'b0);
        end
        for (int i = 0; i < 8; i++) chk_bit("data", d[i], 1'b1, 1'b0);
        chk_bit("parity", p, 1'b1, 1'b0);
    endtask

    initial begin
        int n0;
        int gap;
        sel        = 1'b0;
        bd         = 4;
        inc_en     = 1'b0;
        rdy_lo_chk = 1'b0;
        exp_idle   = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        rst        = 1'b0;

        // reset and idle toggling
        step(); step(); step();
        chk("rst_so", so, 1'b0);
        chk("rst_rdy", rdy, 1'b1);
        chk("rst_fa", fa, 1'b0);
        chk("rst_wd", wd, 1'b0);
        release_align();
        idle_bits(6);
        chk("idle_no_wd", wd_q.size(), 0);

        // single word A5: parity 0, idle resumes with 1
        idle_send(8'hA5);
        sync_bits();
        data_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        chk_bit("idle0", 1'b1, 1'b0, 1'b1);
        exp_idle = 1'b0;
        idle_bits(2);
        chk("a5_wd_cnt", wd_q.size(), 1);

        // back-to-back 01 then 80, each parity 1
        n0 = wd_q.size();
        idle_send(8'h01);
        sync_bits();
        chk("b2b_rdy_load", rdy, 1'b1);
        data_frame(8'h01, 1'b1, 1'b0, 1'b1, 8'h80);
        data_frame(8'h80, 1'b1, 1'b1, 1'b0, 8'h00);
        chk_bit("idle0", 1'b0, 1'b0, 1'b1);
        exp_idle = 1'b1;
        idle_bits(2);
        chk("b2b_wd_cnt", wd_q.size(), n0 + 2);
        gap = (wd_q.size() >= n0 + 2) ? wd_q[n0 + 1] - wd_q[n0] : -1;
        chk("b2b_wd_gap", gap, 40);

        // backpressure: valid held, data increments per cycle -> accepts 10, 34, 5C
        chk("bp_rdy", rdy, 1'b1);
        chk("bp_idle_so", so, exp_idle);
        tx_data  = 8'h0F;
        inc_en   = 1'b1;
        tx_valid = 1'b1;
        step();
        chk("bp_rdy_fall", rdy, 1'b0);
        rdy_lo_chk = 1'b1;
        for (int i = 1; i < bd; i++) begin
            step();
            chk("bp_rdy_lo", rdy, 1'b0);
        end
        sync_bits();
        chk("bp_rdy_rise0", rdy, 1'b1);
        data_frame(8'h10, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("bp_rdy_rise1", rdy, 1'b1);
        data_frame(8'h34, 1'b1, 1'b1, 1'b0, 8'h00);
        tx_valid   = 1'b0;
        inc_en     = 1'b0;
        rdy_lo_chk = 1'b0;
        chk("bp_rdy_rise2", rdy, 1'b1);
        data_frame(8'h5C, 1'b0, 1'b1, 1'b0, 8'h00);
        chk_bit("idle0", 1'b1, 1'b0, 1'b1);
        exp_idle = 1'b0;
        chk("bp_rdy_end", rdy, 1'b1);
        idle_bits(2);

        // reset mid-frame at data bit 4 of 0x10 with 0x77 pending
        n0 = wd_q.size();
        idle_send(8'h10);
        sync_bits();
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        chk_bit("start", 1'b1, 1'b1, 1'b0);
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) chk_bit("data", 1'b0, 1'b1, 1'b0);
        chk("mid_d4_so", so, 1'b1);
        chk("mid_rdy_pend", rdy, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_so", so, 1'b0);
        chk("mid_rst_rdy", rdy, 1'b1);
        chk("mid_rst_fa", fa, 1'b0);
        step(); step();
        release_align();
        idle_bits(4);
        chk("mid_no_wd", wd_q.size(), n0);
        idle_send(8'h3C);
        sync_bits();
        data_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00);
        chk_bit("idle0", 1'b1, 1'b0, 1'b1);

        // BIT_DIV=2 with FF: parity 0, idle resumes with 1
        sel = 1'b1;
        bd  = 2;
        rst = 1'b0;
        step(); step();
        chk("bd2_rst_so", so, 1'b0);
        chk("bd2_rst_rdy", rdy, 1'b1);
        chk("bd2_rst_fa", fa, 1'b0);
        release_align();
        idle_bits(3);
        idle_send(8'hFF);
        sync_bits();
        data_frame(8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);
        chk_bit("idle0", 1'b1, 1'b0, 1'b1);
        exp_idle = 1'b0;
        idle_bits(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
